ref_sram_ctrl: RTL and testbench
================================

Name: ref_sram_ctrl

Overview:
- Sequences the 4-bank reference SRAM rotator that takes one 64-bit word (8 pixels) per cycle and emits 23-pixel reference columns.
- Fetches one search line of reference words from frame memory through a valid/ready request channel and buffers the returns in a credit-managed FIFO.
- Pulses the rotator's next_line before the first word, then streams exactly one word per cycle.
- Gates the downstream PE-array enable with the rotator's readiness flag.

Parameters:
- WORDS_PER_STRIP, 23: words written per SRAM bank before rotation (fixed by the SRAM macro depth).
- STRIPS_PER_LINE, 8: strips per search line; total words per line N = WORDS_PER_STRIP*STRIPS_PER_LINE.
- FIFO_DEPTH, 32: return-buffer depth in 64-bit words; must be a power of 2 and at least 8.
- ADDR_W, 20: frame-memory word-address width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin a line (ignored unless idle)
- base_addr  in  ADDR_W  word address of the first word; sampled on start
- stride  in  ADDR_W  address increment between consecutive words; sampled on start
- busy  out  1  high from the cycle after start until done or abort
- done  out  1  one-cycle pulse when the last word is presented
- underflow  out  1  sticky error flag; cleared by the next accepted start or by reset
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts the request
- mem_req_addr  out  ADDR_W  request address
- mem_rsp_valid  in  1  return data valid; in-order, no backpressure
- mem_rsp_data  in  64  returned word
- sram_next_line  out  1  to the rotator's next_line input
- sram_ref_in  out  64  to the rotator's ref_in input
- sram_ready_in  in  1  from the rotator's sram_ready output
- pe_enable  out  1  reference column valid for the PE array

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - FIFO empty; request, outstanding and pop counters 0.
  - Sampled base_addr and stride registers 0.
- Request path:
  - Address n = base + n*stride, modulo 2^ADDR_W, for n = 0 .. N-1.
  - Request n is accepted when mem_req_valid and mem_req_ready are both high; the address register then advances by stride.
  - Issue rule: mem_req_valid = (state is PREFILL or STREAM) and requests_issued < N and fifo_count + outstanding < FIFO_DEPTH.
  - outstanding increments on an accepted request and decrements on mem_rsp_valid; both in the same cycle leaves it unchanged.
  - A response therefore never finds the FIFO full.
- FIFO: push on mem_rsp_valid. A simultaneous push and pop in the same cycle is legal and leaves the count unchanged.
- States:
  - IDLE:
    - On start, sample base_addr and stride, clear underflow, and go to PREFILL.
    - start in any other state is ignored.
  - PREFILL:
    - Exit when fifo_count == FIFO_DEPTH, or when all N words have been received.
    - On exit, sram_next_line = 1 for exactly one cycle (cycle T), then go to STREAM.
  - STREAM:
    - From cycle T+1, pop one word per cycle to sram_ref_in, registered and aligned with the rotator's address 0. Word 0 is driven at T+1, word k at T+1+k.
    - sram_ref_in = 0 whenever nothing is popped.
    - In the cycle word N-1 is driven: done = 1, then go to IDLE.
    - If the FIFO is empty while pops remain: set underflow, drop pe_enable, drive sram_ref_in = 0, and go to ABORT.
  - ABORT:
    - Stop issuing requests.
    - Discard responses until outstanding == 0, then go to IDLE. done is not asserted.
- busy = (state != IDLE).
- pe_enable = sram_ready_in and (state == STREAM) and a word is popped this cycle.
  - This is low for the rotator's 69-cycle cold fill; the rotator itself flags that condition.
- Reset mid-operation: everything returns to reset values immediately. Responses still in flight from before the reset are the memory side's responsibility; the bench must quiesce them.

Decomposition:
- Package ref_ctrl_pkg:
  - State enum {IDLE, PREFILL, STREAM, ABORT}.
  - Constant WORD_W = 64.
  - Constant SRAM_WORDS = 23.
  - Function clog2 for counter widths.
- Sub-module ref_word_fifo: synchronous FIFO, FIFO_DEPTH x 64, with push, pop, count, empty and full. Same clk/rst_n.
- Everything else stays in ref_sram_ctrl.

Test Plan:
- Basic line: STRIPS_PER_LINE=2, base 0x100, stride 1, req_ready=1, 1-cycle response latency.
  - Requests go to 0x100..0x12D (46 words, capped at 46).
  - One next_line pulse, then 46 consecutive words in order with no gaps.
  - done on the 46th word; busy falls the next cycle.
- Request backpressure: mem_req_ready toggles 1-of-3 cycles during prefill, stride 0x40.
  - Addresses stay correct (base + n*0x40).
  - The stream still starts only after FIFO full, and the output is identical.
- Credit limit: FIFO_DEPTH 32, response latency 50 cycles.
  - fifo_count + outstanding never exceeds 32.
  - No word is lost.
- Underflow: responses stall for 40 cycles mid-stream.
  - underflow set on the first empty pop, pe_enable low, ABORT drains, IDLE reached, no done.
  - The next start clears underflow.
- Readiness gating against the real rotator:
  - pe_enable stays 0 until sram_ready_in rises.
  - After that, ref_out columns match the golden model.
- Reset mid-STREAM, then start ignored while busy:
  - rst_n low at word 20 sets all outputs to 0.
  - A start pulsed during a later PREFILL has no effect on the sampled base_addr.

Source files
------------

// File: rtl/ref_sram_ctrl_pkg.sv
// Shared types and constants for the reference SRAM rotator controller.
package ref_ctrl_pkg;

  localparam int unsigned WORD_W     = 64;
  localparam int unsigned SRAM_WORDS = 23;

  typedef enum logic [1:0] {StIdle, StPrefill, StStream, StAbort} state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ref_sram_ctrl_if.sv
// Frame-memory read channel: valid/ready requests, in-order responses without backpressure.
interface ref_sram_ctrl_if #(
  parameter int unsigned ADDR_W = 20
) ();
  import ref_ctrl_pkg::*;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [WORD_W-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/ref_sram_ctrl_fifo.sv
// Return-word FIFO with first-word-fall-through read and synchronous clear.
module ref_word_fifo
  import ref_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 32,
  parameter int unsigned Width = WORD_W,
  localparam int unsigned PtrW = clog2(Depth),
  localparam int unsigned CntW = clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/ref_sram_ctrl.sv
// Fetches one search line of reference words, prefills a credit-managed FIFO and
// streams one word per cycle into the 4-bank SRAM rotator.
module ref_sram_ctrl
  import ref_ctrl_pkg::*;
#(
  parameter int unsigned WORDS_PER_STRIP = SRAM_WORDS,
  parameter int unsigned STRIPS_PER_LINE = 8,
  parameter int unsigned FIFO_DEPTH      = 32,
  parameter int unsigned ADDR_W          = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              underflow_o,
  ref_sram_ctrl_if.master   mem,
  output logic              sram_next_line_o,
  output logic [WORD_W-1:0] sram_ref_in_o,
  input  logic              sram_ready_in_i,
  output logic              pe_enable_o
);

  localparam int unsigned N    = WORDS_PER_STRIP * STRIPS_PER_LINE;
  localparam int unsigned CntW = clog2(N + 1);
  localparam int unsigned FcW  = clog2(FIFO_DEPTH + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [CntW-1:0]   req_cnt_q, req_cnt_d, pop_cnt_q, pop_cnt_d;
  logic [FcW-1:0]    outst_q, outst_d;
  logic              underflow_q, underflow_d, done_q, done_d;
  logic              next_line_q, next_line_d, vld_q, vld_d;
  logic [WORD_W-1:0] ref_q, ref_d;

  logic              fifo_push, fifo_pop, fifo_clr, fifo_empty, fifo_full;
  logic [WORD_W-1:0] fifo_rdata;
  logic [FcW-1:0]    fifo_count;
  logic              active, req_valid, req_fire, rsp_take;

  ref_word_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (fifo_clr),
    .push_i  (fifo_push),
    .wdata_i (mem.mem_rsp_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Credit check counts words in flight so a response can never find the FIFO full.
  assign active    = (state_q == StPrefill) || (state_q == StStream);
  assign req_valid = active && (req_cnt_q < CntW'(N)) &&
                     ((32'(fifo_count) + 32'(outst_q)) < FIFO_DEPTH);
  assign req_fire  = req_valid && mem.mem_req_ready;
  assign rsp_take  = mem.mem_rsp_valid && (outst_q != '0);
  assign fifo_push = mem.mem_rsp_valid && active;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    req_cnt_d   = req_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    outst_d     = outst_q;
    underflow_d = underflow_q;
    done_d      = 1'b0;
    next_line_d = 1'b0;
    vld_d       = 1'b0;
    ref_d       = '0;
    fifo_pop    = 1'b0;
    fifo_clr    = 1'b0;

    if (req_fire) begin
      addr_d    = addr_q + stride_q;
      req_cnt_d = req_cnt_q + 1'b1;
    end
    case ({req_fire, rsp_take})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d     = StPrefill;
          addr_d      = base_addr_i;
          stride_d    = stride_i;
          underflow_d = 1'b0;
          req_cnt_d   = '0;
          pop_cnt_d   = '0;
          fifo_clr    = 1'b1;
        end
      end
      StPrefill: begin
        if (fifo_full || ((req_cnt_q == CntW'(N)) && (outst_q == '0))) begin
          next_line_d = 1'b1;
          state_d     = StStream;
        end
      end
      StStream: begin
        // The cycle after the last pop presents word N-1 together with done.
        if (pop_cnt_q == CntW'(N)) begin
          state_d = StIdle;
        end else if (fifo_empty) begin
          underflow_d = 1'b1;
          state_d     = StAbort;
        end else begin
          fifo_pop  = 1'b1;
          vld_d     = 1'b1;
          ref_d     = fifo_rdata;
          pop_cnt_d = pop_cnt_q + 1'b1;
          done_d    = (pop_cnt_q == CntW'(N - 1));
        end
      end
      StAbort: begin
        fifo_clr = 1'b1;
        if (outst_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      stride_q    <= '0;
      req_cnt_q   <= '0;
      pop_cnt_q   <= '0;
      outst_q     <= '0;
      underflow_q <= 1'b0;
      done_q      <= 1'b0;
      next_line_q <= 1'b0;
      vld_q       <= 1'b0;
      ref_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      req_cnt_q   <= req_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      outst_q     <= outst_d;
      underflow_q <= underflow_d;
      done_q      <= done_d;
      next_line_q <= next_line_d;
      vld_q       <= vld_d;
      ref_q       <= ref_d;
    end
  end

  assign busy_o            = (state_q != StIdle);
  assign done_o            = done_q;
  assign underflow_o       = underflow_q;
  assign sram_next_line_o  = next_line_q;
  assign sram_ref_in_o     = ref_q;
  assign pe_enable_o       = sram_ready_in_i && (state_q == StStream) && vld_q;
  assign mem.mem_req_valid = req_valid;
  assign mem.mem_req_addr  = addr_q;

endmodule

// File: tb/tb_ref_sram_ctrl.sv
// Scoreboard bench for ref_sram_ctrl: a memory model answers requests, a monitor checks outputs.
module tb_ref_sram_ctrl;
  import ref_ctrl_pkg::*;

  localparam int unsigned AW     = 20;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned STRIPS = 2;
  localparam int unsigned N      = SRAM_WORDS * STRIPS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base = '0, stride = '0;
  logic          busy, done, underflow, next_line, pe, ready_in;
  logic [63:0]   ref_w;

  ref_sram_ctrl_if #(.ADDR_W(AW)) mem_if ();

  ref_sram_ctrl #(
    .WORDS_PER_STRIP (SRAM_WORDS),
    .STRIPS_PER_LINE (STRIPS),
    .FIFO_DEPTH      (DEPTH),
    .ADDR_W          (AW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start),
    .base_addr_i      (base),
    .stride_i         (stride),
    .busy_o           (busy),
    .done_o           (done),
    .underflow_o      (underflow),
    .mem              (mem_if.master),
    .sram_next_line_o (next_line),
    .sram_ref_in_o    (ref_w),
    .sram_ready_in_i  (ready_in),
    .pe_enable_o      (pe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  logic [AW-1:0] exp_addr_q[$];
  logic [63:0]   exp_word_q[$];
  pend_t         pend_q[$];

  int errors = 0, checks = 0;
  int words_line, nl_cnt, done_cnt, rsp_cnt, acc_cnt, max_inflight;
  int lat = 1, stall_until = 0;
  bit nl_seen, stall_on_nl, ready_mode, flush, uf_prev, done_prev;

  function automatic logic [63:0] data_of(input logic [AW-1:0] a);
    return {12'h5A5, a, 12'hC3C, ~a};
  endfunction

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endfunction

  task automatic monitor_step();
    if (busy && ref_w != '0) begin
      words_line++;
      if (exp_word_q.size() > 0) check("word", ref_w, exp_word_q.pop_front());
      else fail_now("extra_word");
      check("pe_gate", 64'(pe), 64'(ready_in));
    end else if (pe) begin
      fail_now("pe_without_word");
    end
    if (next_line) begin
      nl_cnt++;
      nl_seen = 1'b1;
      check("prefill_fill", 64'(rsp_cnt), 64'(DEPTH));
      if (stall_on_nl) stall_until = cyc + 40;
    end
    if (done) begin
      done_cnt++;
      check("done_align", 64'(words_line), 64'(N));
    end
    if (done_prev) check("busy_after_done", 64'(busy), 64'd0);
    if (underflow && !uf_prev) begin
      check("abort_pe", 64'(pe), 64'd0);
      check("abort_ref", ref_w, 64'd0);
    end
    done_prev = done;
    uf_prev   = underflow;
  endtask

  task automatic mem_step();
    logic r;
    int   inflight;
    if (flush) begin
      pend_q.delete();
      mem_if.mem_req_ready = 1'b0;
      mem_if.mem_rsp_valid = 1'b0;
      mem_if.mem_rsp_data  = '0;
      return;
    end
    // Values driven here are what the next rising edge samples.
    r = !ready_mode || nl_seen || (cyc % 3 == 0);
    mem_if.mem_req_ready = r;
    if (mem_if.mem_req_valid && r) begin
      acc_cnt++;
      pend_q.push_back('{addr: mem_if.mem_req_addr, due: cyc + (nl_seen ? 1 : lat)});
      if (exp_addr_q.size() > 0) check("req_addr", 64'(mem_if.mem_req_addr),
                                       64'(exp_addr_q.pop_front()));
      else fail_now("extra_req");
    end
    inflight = acc_cnt - words_line;
    if (inflight > max_inflight) max_inflight = inflight;
    if (pend_q.size() > 0 && cyc >= pend_q[0].due && cyc >= stall_until) begin
      mem_if.mem_rsp_valid = 1'b1;
      mem_if.mem_rsp_data  = data_of(pend_q[0].addr);
      void'(pend_q.pop_front());
      rsp_cnt++;
    end else begin
      mem_if.mem_rsp_valid = 1'b0;
      mem_if.mem_rsp_data  = '0;
    end
  endtask

  always @(negedge clk) begin
    monitor_step();
    mem_step();
  end

  task automatic start_line(input logic [AW-1:0] b, input logic [AW-1:0] s);
    logic [AW-1:0] a;
    @(posedge clk);
    #1;
    words_line = 0; nl_cnt = 0; done_cnt = 0; rsp_cnt = 0; acc_cnt = 0;
    max_inflight = 0; nl_seen = 1'b0;
    a = b;
    for (int n = 0; n < int'(N); n++) begin
      exp_addr_q.push_back(a);
      exp_word_q.push_back(data_of(a));
      a = a + s;
    end
    start = 1'b1; base = b; stride = s;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while (busy && i < budget) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic end_line(input string name);
    check({name, "_nl"}, 64'(nl_cnt), 64'd1);
    check({name, "_done"}, 64'(done_cnt), 64'd1);
    check({name, "_words"}, 64'(words_line), 64'(N));
    check({name, "_addr_left"}, 64'(exp_addr_q.size()), 64'd0);
    check({name, "_word_left"}, 64'(exp_word_q.size()), 64'd0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_uf"}, 64'(underflow), 64'd0);
    check({name, "_req"}, 64'(mem_if.mem_req_valid), 64'd0);
    check({name, "_nl"}, 64'(next_line), 64'd0);
    check({name, "_ref"}, ref_w, 64'd0);
    check({name, "_pe"}, 64'(pe), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ready_in = 1'b1;
    mem_if.mem_req_ready = 1'b0;
    mem_if.mem_rsp_valid = 1'b0;
    mem_if.mem_rsp_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;

    // Basic line: 0x100..0x12D, stride 1.
    start_line(20'h00100, 20'd1);
    wait_idle("basic_finish", 400);
    end_line("basic");

    // Request backpressure during prefill.
    ready_mode = 1'b1;
    start_line(20'h00200, 20'h00040);
    wait_idle("bp_finish", 600);
    end_line("bp");
    ready_mode = 1'b0;

    // Long prefill latency exercises the credit limit.
    lat = 50;
    start_line(20'hFFFF0, 20'd3);
    wait_idle("credit_finish", 800);
    end_line("credit");
    check("credit_max", 64'(max_inflight), 64'(DEPTH));
    lat = 1;

    // Responses stall after next_line: FIFO drains and the line aborts.
    stall_on_nl = 1'b1;
    start_line(20'h00500, 20'd2);
    wait_idle("uf_finish", 400);
    check("uf_flag", 64'(underflow), 64'd1);
    check("uf_no_done", 64'(done_cnt), 64'd0);
    check("uf_words", 64'(words_line), 64'(DEPTH));
    stall_on_nl = 1'b0;
    stall_until = 0;
    exp_addr_q.delete();
    exp_word_q.delete();

    // Next start clears underflow; readiness held low for a while after next_line.
    ready_in = 1'b0;
    start_line(20'h00600, 20'd1);
    check("uf_cleared", 64'(underflow), 64'd0);
    for (int i = 0; i < 300 && !nl_seen; i++) begin
      @(posedge clk);
      #1;
    end
    check("gate_nl_seen", 64'(nl_seen), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    ready_in = 1'b1;
    wait_idle("gate_finish", 400);
    end_line("gate");

    // Reset mid-stream at word 20.
    start_line(20'h00700, 20'd5);
    for (int i = 0; i < 400 && words_line < 20; i++) begin
      @(posedge clk);
      #1;
    end
    check("rst_reach20", 64'(words_line), 64'd20);
    rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    flush = 1'b1;
    exp_addr_q.delete();
    exp_word_q.delete();
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b0;
    rst_n = 1'b1;

    // A second start during prefill must not disturb the sampled base address.
    start_line(20'h00800, 20'd7);
    repeat (3) @(posedge clk);
    #1;
    check("ignored_start_busy", 64'(busy), 64'd1);
    start = 1'b1; base = 20'hABCDE; stride = 20'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle("ign_finish", 400);
    end_line("ign");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
